// File: rtl/vx_fetch_pkg.sv
// Shared types and constants for the fetch request stage.
// The fetch-stage modules take their widths from here.
package vx_fetch_pkg;

    localparam int FETCH_NUM_WARPS   = 4;
    localparam int FETCH_NUM_THREADS = 4;
    localparam int FETCH_XLEN        = 32;
    localparam int FETCH_WORD_SIZE   = 4;

    localparam int NW_BITS         = $clog2(FETCH_NUM_WARPS);
    localparam int WORD_ADDR_WIDTH = FETCH_XLEN - $clog2(FETCH_WORD_SIZE);

    typedef struct packed {
        logic [NW_BITS-1:0]           wid;
        logic [FETCH_XLEN-1:0]        PC;
        logic [FETCH_NUM_THREADS-1:0] tmask;
    } fetch_req_t;

    typedef struct packed {
        logic [NW_BITS-1:0]           wid;
        logic [FETCH_XLEN-1:0]        PC;
        logic [FETCH_NUM_THREADS-1:0] tmask;
        logic [31:0]                  instr;
    } fetch_rsp_t;

endpackage

// File: rtl/vx_fetch_meta_ram.sv
// Per-warp metadata store: one write port, one asynchronous read port, no reset.
module vx_fetch_meta_ram #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 36,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Capture {PC, tmask} for a warp when its fetch is issued.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vx_fetch_req_stage.sv
// Fetch request stage: issues word-addressed icache requests tagged by warp id,
// parks {PC, tmask} per warp while outstanding and rejoins it with the response.
// Parameters must agree with the widths in vx_fetch_pkg.
module vx_fetch_req_stage
    import vx_fetch_pkg::*;
#(
    parameter int NUM_WARPS   = FETCH_NUM_WARPS,
    parameter int NUM_THREADS = FETCH_NUM_THREADS,
    parameter int XLEN        = FETCH_XLEN,
    parameter int WORD_SIZE   = FETCH_WORD_SIZE
) (
    input  logic                               clk,
    input  logic                               reset,

    input  logic                               ifetch_req_valid,
    input  logic [NW_BITS-1:0]                 ifetch_req_wid,
    input  logic [XLEN-1:0]                    ifetch_req_PC,
    input  logic [NUM_THREADS-1:0]             ifetch_req_tmask,
    output logic                               ifetch_req_ready,

    output logic                               icache_req_valid,
    output logic [WORD_ADDR_WIDTH-1:0]         icache_req_addr,
    output logic [NW_BITS-1:0]                 icache_req_tag,
    input  logic                               icache_req_ready,

    input  logic                               icache_rsp_valid,
    input  logic [31:0]                        icache_rsp_data,
    input  logic [NW_BITS-1:0]                 icache_rsp_tag,
    output logic                               icache_rsp_ready,

    output logic                               ifetch_rsp_valid,
    output logic [NW_BITS-1:0]                 ifetch_rsp_wid,
    output logic [XLEN-1:0]                    ifetch_rsp_PC,
    output logic [NUM_THREADS-1:0]             ifetch_rsp_tmask,
    output logic [31:0]                        ifetch_rsp_instr,
    input  logic                               ifetch_rsp_ready,

    output logic [$clog2(NUM_WARPS+1)-1:0]     pending_count,
    output logic                               busy
);

    localparam int OFS_W  = $clog2(WORD_SIZE);
    localparam int CNT_W  = $clog2(NUM_WARPS + 1);
    localparam int META_W = XLEN + NUM_THREADS;

    fetch_req_t           req_in;
    fetch_rsp_t           rsp_q;
    logic                 req_fire;
    logic                 rsp_fire;
    logic                 cnt_inc;
    logic                 cnt_dec;
    logic [NUM_WARPS-1:0] pending;
    logic [META_W-1:0]    meta_rdata;

    assign req_in = '{wid: ifetch_req_wid, PC: ifetch_req_PC, tmask: ifetch_req_tmask};

    // A warp with a fetch in flight is blocked; a same-cycle response for it
    // does not bypass, so the retry lands one cycle later.
    assign ifetch_req_ready = (!icache_req_valid || icache_req_ready) && !pending[req_in.wid];
    assign req_fire         = ifetch_req_valid && ifetch_req_ready;

    assign icache_rsp_ready = !ifetch_rsp_valid || ifetch_rsp_ready;
    assign rsp_fire         = icache_rsp_valid && icache_rsp_ready;

    vx_fetch_meta_ram #(
        .DEPTH (NUM_WARPS),
        .WIDTH (META_W),
        .AW    (NW_BITS)
    ) meta_ram (
        .clk   (clk),
        .we    (req_fire),
        .waddr (req_in.wid),
        .wdata ({req_in.PC, req_in.tmask}),
        .raddr (icache_rsp_tag),
        .rdata (meta_rdata)
    );

    // Request pipe register: load on accept, hold while the icache stalls.
    always_ff @(posedge clk) begin
        if (reset)                 icache_req_valid <= 1'b0;
        else if (req_fire)         icache_req_valid <= 1'b1;
        else if (icache_req_ready) icache_req_valid <= 1'b0;
        if (req_fire) begin
            icache_req_addr <= req_in.PC[XLEN-1:OFS_W];
            icache_req_tag  <= req_in.wid;
        end
    end

    // Response pipe register: join icache data with the parked metadata.
    always_ff @(posedge clk) begin
        if (reset)                 ifetch_rsp_valid <= 1'b0;
        else if (rsp_fire)         ifetch_rsp_valid <= 1'b1;
        else if (ifetch_rsp_ready) ifetch_rsp_valid <= 1'b0;
        if (rsp_fire) begin
            rsp_q <= '{wid:   icache_rsp_tag,
                       PC:    meta_rdata[META_W-1:NUM_THREADS],
                       tmask: meta_rdata[NUM_THREADS-1:0],
                       instr: icache_rsp_data};
        end
    end

    assign ifetch_rsp_wid   = rsp_q.wid;
    assign ifetch_rsp_PC    = rsp_q.PC;
    assign ifetch_rsp_tmask = rsp_q.tmask;
    assign ifetch_rsp_instr = rsp_q.instr;

    // Per-warp outstanding flags; a set for a new fetch wins over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (rsp_fire) pending[icache_rsp_tag] <= 1'b0;
            if (req_fire) pending[req_in.wid]     <= 1'b1;
        end
    end

    // Only responses that retire a real pending fetch decrement, so a stale
    // tag can never drive the count below zero.
    assign cnt_inc = req_fire;
    assign cnt_dec = rsp_fire && pending[icache_rsp_tag] && (pending_count != '0);

    // Outstanding-access counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_count <= '0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   pending_count <= pending_count + CNT_W'(1);
                2'b01:   pending_count <= pending_count - CNT_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    assign busy = (pending_count != '0);

`ifndef SYNTHESIS
    // Flag stale response tags and misaligned fetch PCs in simulation.
    always @(posedge clk) begin
        if (!reset) begin
            if (rsp_fire)
                assert (pending[icache_rsp_tag])
                else $warning("icache response for idle warp %0d", icache_rsp_tag);
            if (req_fire)
                assert (req_in.PC[OFS_W-1:0] == '0)
                else $warning("misaligned fetch PC %h", req_in.PC);
        end
    end
`endif

endmodule

// File: tb/tb_vx_fetch_req_stage.sv
// Directed bench for vx_fetch_req_stage: a vector table for the single-cycle
// flows plus hand sequences for stalls, decode backpressure and mid-flight reset.
module tb_vx_fetch_req_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ifetch_req_valid;
    logic [1:0]  ifetch_req_wid;
    logic [31:0] ifetch_req_PC;
    logic [3:0]  ifetch_req_tmask;
    logic        ifetch_req_ready;
    logic        icache_req_valid;
    logic [29:0] icache_req_addr;
    logic [1:0]  icache_req_tag;
    logic        icache_req_ready;
    logic        icache_rsp_valid;
    logic [31:0] icache_rsp_data;
    logic [1:0]  icache_rsp_tag;
    logic        icache_rsp_ready;
    logic        ifetch_rsp_valid;
    logic [1:0]  ifetch_rsp_wid;
    logic [31:0] ifetch_rsp_PC;
    logic [3:0]  ifetch_rsp_tmask;
    logic [31:0] ifetch_rsp_instr;
    logic        ifetch_rsp_ready;
    logic [2:0]  pending_count;
    logic        busy;

    int checks = 0;
    int errors = 0;

    vx_fetch_req_stage dut (
        .clk              (clk),
        .reset            (reset),
        .ifetch_req_valid (ifetch_req_valid),
        .ifetch_req_wid   (ifetch_req_wid),
        .ifetch_req_PC    (ifetch_req_PC),
        .ifetch_req_tmask (ifetch_req_tmask),
        .ifetch_req_ready (ifetch_req_ready),
        .icache_req_valid (icache_req_valid),
        .icache_req_addr  (icache_req_addr),
        .icache_req_tag   (icache_req_tag),
        .icache_req_ready (icache_req_ready),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_tag   (icache_rsp_tag),
        .icache_rsp_ready (icache_rsp_ready),
        .ifetch_rsp_valid (ifetch_rsp_valid),
        .ifetch_rsp_wid   (ifetch_rsp_wid),
        .ifetch_rsp_PC    (ifetch_rsp_PC),
        .ifetch_rsp_tmask (ifetch_rsp_tmask),
        .ifetch_rsp_instr (ifetch_rsp_instr),
        .ifetch_rsp_ready (ifetch_rsp_ready),
        .pending_count    (pending_count),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rv;  logic [1:0] wid; logic [31:0] pc; logic [3:0] tm; logic icrdy;
        logic        sv;  logic [31:0] sdata; logic [1:0] stag; logic frdy;
        logic        e_rrdy; logic e_srdy;
        logic        e_qv; logic [29:0] e_addr; logic [1:0] e_tag;
        logic        e_fv; logic [1:0] e_wid; logic [31:0] e_pc; logic [3:0] e_tm; logic [31:0] e_instr;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vt [18];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [1:0] wid, input logic [31:0] pc,
                         input logic [3:0] tm, input logic icrdy, input logic sv,
                         input logic [31:0] sdata, input logic [1:0] stag, input logic frdy);
        ifetch_req_valid = rv;  ifetch_req_wid = wid; ifetch_req_PC = pc;
        ifetch_req_tmask = tm;  icache_req_ready = icrdy;
        icache_rsp_valid = sv;  icache_rsp_data = sdata; icache_rsp_tag = stag;
        ifetch_rsp_ready = frdy;
    endtask

    task automatic pre(input string nm, input logic rrdy, input logic srdy);
        #1;
        chk({nm, ".ifetch_req_ready"}, 64'(ifetch_req_ready), 64'(rrdy));
        chk({nm, ".icache_rsp_ready"}, 64'(icache_rsp_ready), 64'(srdy));
    endtask

    task automatic post(input string nm, input logic qv, input logic [29:0] addr,
                        input logic [1:0] tag, input logic fv, input logic [1:0] wid,
                        input logic [31:0] pc, input logic [3:0] tm, input logic [31:0] instr,
                        input logic [2:0] cnt);
        chk({nm, ".icache_req_valid"}, 64'(icache_req_valid), 64'(qv));
        if (qv) begin
            chk({nm, ".icache_req_addr"}, 64'(icache_req_addr), 64'(addr));
            chk({nm, ".icache_req_tag"},  64'(icache_req_tag),  64'(tag));
        end
        chk({nm, ".ifetch_rsp_valid"}, 64'(ifetch_rsp_valid), 64'(fv));
        if (fv) begin
            chk({nm, ".ifetch_rsp_wid"},   64'(ifetch_rsp_wid),   64'(wid));
            chk({nm, ".ifetch_rsp_PC"},    64'(ifetch_rsp_PC),    64'(pc));
            chk({nm, ".ifetch_rsp_tmask"}, 64'(ifetch_rsp_tmask), 64'(tm));
            chk({nm, ".ifetch_rsp_instr"}, 64'(ifetch_rsp_instr), 64'(instr));
        end
        chk({nm, ".pending_count"}, 64'(pending_count), 64'(cnt));
        chk({nm, ".busy"}, 64'(busy), 64'(cnt != 3'd0));
    endtask

    initial begin
        // basic fetch of warp 1
        vt[0]  = '{1'b1, 2'd1, 32'h8000_0010, 4'b1011, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h2000_0004, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1};
        vt[1]  = '{1'b0, 2'd1, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0513, 2'd1, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd1, 32'h8000_0010, 4'b1011, 32'h0000_0513, 3'd0};
        vt[2]  = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0};
        // four warps back to back, then out-of-order returns 2,0,3,1
        vt[3]  = '{1'b1, 2'd0, 32'h100, 4'b0001, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h40, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1};
        vt[4]  = '{1'b1, 2'd1, 32'h204, 4'b0011, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h81, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd2};
        vt[5]  = '{1'b1, 2'd2, 32'h308, 4'b0111, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'hC2, 2'd2, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd3};
        vt[6]  = '{1'b1, 2'd3, 32'h40C, 4'b1111, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h103, 2'd3, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd4};
        vt[7]  = '{1'b1, 2'd0, 32'h500, 4'b0001, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd4};
        vt[8]  = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hAAAA_0002, 2'd2, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd2, 32'h308, 4'b0111, 32'hAAAA_0002, 3'd3};
        vt[9]  = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'hBBBB_0000, 2'd0, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd0, 32'h100, 4'b0001, 32'hBBBB_0000, 3'd2};
        vt[10] = '{1'b0, 2'd1, 32'h0, 4'h0, 1'b1, 1'b1, 32'hCCCC_0003, 2'd3, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd3, 32'h40C, 4'b1111, 32'hCCCC_0003, 3'd1};
        vt[11] = '{1'b0, 2'd1, 32'h0, 4'h0, 1'b1, 1'b1, 32'hDDDD_0001, 2'd1, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd1, 32'h204, 4'b0011, 32'hDDDD_0001, 3'd0};
        // same-warp collision, then inc+dec in one cycle on different warps
        vt[12] = '{1'b1, 2'd3, 32'h600, 4'b1010, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h180, 2'd3, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1};
        vt[13] = '{1'b1, 2'd3, 32'h700, 4'b0101, 1'b1, 1'b1, 32'h1234_5678, 2'd3, 1'b1, 1'b0, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd3, 32'h600, 4'b1010, 32'h1234_5678, 3'd0};
        vt[14] = '{1'b1, 2'd3, 32'h700, 4'b0101, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h1C0, 2'd3, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1};
        vt[15] = '{1'b1, 2'd2, 32'h800, 4'b0110, 1'b1, 1'b1, 32'h0000_0073, 2'd3, 1'b1, 1'b1, 1'b1,
                   1'b1, 30'h200, 2'd2, 1'b1, 2'd3, 32'h700, 4'b0101, 32'h0000_0073, 3'd1};
        vt[16] = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0013, 2'd2, 1'b1, 1'b1, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b1, 2'd2, 32'h800, 4'b0110, 32'h0000_0013, 3'd0};
        vt[17] = '{1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1, 1'b1, 1'b1,
                   1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0};

        reset = 1'b1;
        drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        tick();
        tick();
        post("reset", 1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(vt[i].rv, vt[i].wid, vt[i].pc, vt[i].tm, vt[i].icrdy,
                  vt[i].sv, vt[i].sdata, vt[i].stag, vt[i].frdy);
            pre(nm, vt[i].e_rrdy, vt[i].e_srdy);
            tick();
            post(nm, vt[i].e_qv, vt[i].e_addr, vt[i].e_tag, vt[i].e_fv, vt[i].e_wid,
                 vt[i].e_pc, vt[i].e_tm, vt[i].e_instr, vt[i].e_cnt);
        end

        // icache backpressure: first request parks, second waits
        drive(1'b1, 2'd1, 32'h900, 4'b0011, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        pre("bp_acc1", 1'b1, 1'b1);
        tick();
        post("bp_acc1", 1'b1, 30'h240, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1);
        drive(1'b1, 2'd2, 32'hA00, 4'b1100, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            pre($sformatf("bp_stall%0d", c), 1'b0, 1'b1);
            tick();
            post($sformatf("bp_stall%0d", c), 1'b1, 30'h240, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd1);
        end
        icache_req_ready = 1'b1;
        pre("bp_release", 1'b1, 1'b1);
        tick();
        post("bp_release", 1'b1, 30'h280, 2'd2, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd2);
        ifetch_req_valid = 1'b0;
        tick();
        post("bp_drain", 1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd2);

        // decode stall: first response held, second refused until release
        drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0011, 2'd1, 1'b0);
        pre("ds_first", 1'b1, 1'b1);
        tick();
        post("ds_first", 1'b0, 30'h0, 2'd0, 1'b1, 2'd1, 32'h900, 4'b0011, 32'h0000_0011, 3'd1);
        icache_rsp_data = 32'h0000_0022;
        icache_rsp_tag  = 2'd2;
        for (int c = 0; c < 2; c++) begin
            pre($sformatf("ds_hold%0d", c), 1'b1, 1'b0);
            tick();
            post($sformatf("ds_hold%0d", c), 1'b0, 30'h0, 2'd0, 1'b1, 2'd1, 32'h900, 4'b0011, 32'h0000_0011, 3'd1);
        end
        ifetch_rsp_ready = 1'b1;
        pre("ds_release", 1'b1, 1'b1);
        tick();
        post("ds_release", 1'b0, 30'h0, 2'd0, 1'b1, 2'd2, 32'hA00, 4'b1100, 32'h0000_0022, 3'd0);
        icache_rsp_valid = 1'b0;
        tick();
        post("ds_drain", 1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0);

        // reset with two outstanding and a request parked in the register
        drive(1'b1, 2'd0, 32'h100, 4'b0001, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        tick();
        drive(1'b1, 2'd1, 32'h200, 4'b0010, 1'b1, 1'b0, 32'h0, 2'd0, 1'b1);
        tick();
        post("rst_setup", 1'b1, 30'h80, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd2);
        drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 2'd0, 1'b1);
        tick();
        post("rst_parked", 1'b1, 30'h80, 2'd1, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd2);
        reset = 1'b1;
        tick();
        post("rst_mid", 1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0);
        reset = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0067, 2'd1, 1'b1);
        pre("stale_rsp", 1'b1, 1'b1);
        tick();
        chk("stale_rsp.ifetch_rsp_valid", 64'(ifetch_rsp_valid), 64'(1'b1));
        chk("stale_rsp.ifetch_rsp_wid", 64'(ifetch_rsp_wid), 64'(2'd1));
        chk("stale_rsp.ifetch_rsp_instr", 64'(ifetch_rsp_instr), 64'(32'h0000_0067));
        chk("stale_rsp.pending_count", 64'(pending_count), 64'(3'd0));
        icache_rsp_valid = 1'b0;
        tick();
        post("stale_drain", 1'b0, 30'h0, 2'd0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_fetch_req_stage.md
Name: vx_fetch_req_stage

Overview:
- Fetch-side stage between the warp scheduler and the instruction cache.
- Accepts per-warp fetch requests {wid, PC, tmask} and issues word-addressed icache requests tagged with the warp id.
- Holds per-warp metadata while the access is outstanding.
- Joins icache responses back with that metadata and forwards {wid, PC, tmask, instr} to decode.

Parameters:
NUM_WARPS, 4, number of hardware warps (power of two, >=2)
NUM_THREADS, 4, threads per warp (tmask width)
XLEN, 32, PC width in bits
WORD_SIZE, 4, icache word size in bytes (power of two)
NW_BITS, clog2(NUM_WARPS), warp id width; also icache tag width
WORD_ADDR_WIDTH, XLEN-clog2(WORD_SIZE), icache word address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ifetch_req_valid  in  1  scheduler request valid
ifetch_req_wid  in  NW_BITS  requesting warp
ifetch_req_PC  in  XLEN  fetch PC (WORD_SIZE-aligned)
ifetch_req_tmask  in  NUM_THREADS  thread mask
ifetch_req_ready  out  1  request accepted when valid&ready
icache_req_valid  out  1  icache request valid
icache_req_addr  out  WORD_ADDR_WIDTH  word address
icache_req_tag  out  NW_BITS  tag = wid
icache_req_ready  in  1  icache accepts
icache_rsp_valid  in  1  icache response valid
icache_rsp_data  in  32  instruction word
icache_rsp_tag  in  NW_BITS  returned tag
icache_rsp_ready  out  1  response accepted
ifetch_rsp_valid  out  1  decode-side valid
ifetch_rsp_wid  out  NW_BITS  warp id
ifetch_rsp_PC  out  XLEN  PC
ifetch_rsp_tmask  out  NUM_THREADS  thread mask
ifetch_rsp_instr  out  32  instruction
ifetch_rsp_ready  in  1  decode accepts
pending_count  out  clog2(NUM_WARPS+1)  outstanding icache accesses
busy  out  1  pending_count != 0

Behaviour:
- Reset (sync, high): icache_req_valid=0, ifetch_rsp_valid=0, pending[]=0, pending_count=0, busy=0. Req/rsp payload registers and the metadata RAM are not reset.
- Request register: a single-entry pipe register.
  - ifetch_req_ready = (!icache_req_valid | icache_req_ready) & !pending[ifetch_req_wid].
  - On accept: next cycle icache_req_valid=1, addr=PC[XLEN-1:clog2(WORD_SIZE)], tag=wid. Latency is 1 cycle; full throughput under a back-to-back ready.
  - Also on accept: meta[wid] <= {PC, tmask} and pending[wid] <= 1.
  - The request register holds its payload stable while icache_req_valid & !icache_req_ready.
- Response register: a single-entry pipe register.
  - icache_rsp_ready = !ifetch_rsp_valid | ifetch_rsp_ready.
  - On handshake: next cycle ifetch_rsp_valid=1 with wid=tag, {PC,tmask}=meta[tag], instr=data; pending[tag] <= 0. Latency is 1 cycle.
- Same-warp collision: a response clearing pending[x] in the same cycle a request for warp x is presented blocks the request that cycle (ready uses the current pending value). The request is accepted the next cycle.
- pending_count: +1 per request accept, -1 per response handshake; both in one cycle leave it unchanged. It never exceeds NUM_WARPS, so it never wraps.
- Unexpected response (tag with pending[tag]=0, e.g. after a mid-flight reset): the handshake completes and ifetch_rsp is still produced. A simulation assertion fires. In synthesis, pending_count saturates at 0.
- Reset mid-operation: all valids drop on the next edge. Any in-flight request is abandoned and decode sees no spurious valid.
- Misaligned PC (low clog2(WORD_SIZE) bits non-zero): simulation assertion; the low bits are truncated.

Decomposition:
- Shared fetch package:
  - fetch request struct {wid, PC, tmask}.
  - fetch response struct {wid, PC, tmask, instr}.
  - constants NW_BITS and WORD_ADDR_WIDTH.
- Sub-module vx_fetch_meta_ram: NUM_WARPS x (XLEN+NUM_THREADS) register-file RAM with one write port and one asynchronous read port, no reset. The pending bit vector and the counter stay in the top module.

Test Plan:
1. Basic: wid=1, PC=0x8000_0010, tmask=4'b1011, icache ready. Next cycle: icache_req addr=0x2000_0004, tag=1. Response 0x0000_0513/tag1 -> ifetch_rsp next cycle with wid=1, PC=0x8000_0010, tmask=1011, instr=0x00000513. pending_count goes 0->1->0.
2. Out-of-order: issue wid 0,1,2,3 back-to-back. pending_count=4 and all ready drops (every warp pending). Responses returned with tags 2,0,3,1 -> each ifetch_rsp carries the matching PC/tmask.
3. Backpressure: icache_req_ready=0 for 5 cycles. addr/tag held stable; second request (wid=2) is stalled with ifetch_req_ready=0. Release -> both issued in order.
4. Decode stall: ifetch_rsp_ready=0 while two responses arrive. First is held; icache_rsp_ready=0 for the second. Release -> both delivered, none lost.
5. Collision: response tag=3 and a new request wid=3 in the same cycle. Request accepted exactly one cycle later; pending_count unchanged across the overlap.
6. Reset with 2 outstanding plus a valid held in the request register. All valids =0 and pending_count=0 on the next edge. A stale response then triggers the assertion with count staying 0.
